opl_exp_conv: RTL and testbench

//  Log-to-linear converter for the FM operator path; the inverse of the phase->log-sin lookup.

---
 rtl/opl_pkg.sv | 14 +
 rtl/lut_exp.sv | 26 ++
 rtl/opl_exp_conv.sv | 120 ++++++++++++
 tb/tb_opl_exp_conv.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl_pkg.sv
// Shared FM-operator definitions: log-domain attenuation and linear sample widths.
package opl_pkg;

   localparam int ATTEN_W   = 13;
   localparam int SAMPLE_W  = 14;
   localparam int EXP_LUT_W = 10;
   localparam int EXP_IDX_W = 8;
   localparam int EXP_DEPTH = 1 << EXP_IDX_W;
   localparam int MANT_W    = EXP_LUT_W + 2;

   typedef logic [ATTEN_W-1:0]         atten_t;
   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/lut_exp.sv
// Exponent ROM: EXP[i] = round((2^(i/256) - 1) * 1024), a combinational distributed ROM.
module lut_exp
   import opl_pkg::*;
(
   input  logic [EXP_IDX_W-1:0] i_idx,
   output logic [EXP_LUT_W-1:0] o_val
);

   function automatic logic [EXP_LUT_W-1:0] exp_entry(input int i);
      real v;
      v = (2.0 ** (real'(i) / 256.0) - 1.0) * 1024.0;
      return EXP_LUT_W'($rtoi(v + 0.5));
   endfunction

   // NOTE: a ROM is constant contents, so it has no reset and no clock; every entry is an
   // elaboration-time constant and the read is a pure mux.
   logic [EXP_LUT_W-1:0] w_rom [EXP_DEPTH];

   for (genvar g = 0; g < EXP_DEPTH; g++) begin : g_rom
      localparam logic [EXP_LUT_W-1:0] ENTRY = exp_entry(g);
      assign w_rom[g] = ENTRY;
   end

   assign o_val = w_rom[i_idx];

endmodule

// File: rtl/opl_exp_conv.sv
// Log-to-linear operator converter (2-stage pipeline) plus per-frame slot accumulator.
// Optional EXP_ACC_SAT_EN: accumulator adds saturate instead of wrapping.
module opl_exp_conv
   import opl_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [ATTEN_W-1:0]  in_atten,
   input  logic                in_sign,
   input  logic                in_last,
   output logic                out_valid,
   output logic [SAMPLE_W-1:0] out_sample,
   output logic                acc_valid,
   output logic [ACC_W-1:0]    acc_sample
);

   logic [EXP_LUT_W-1:0] w_lut;

   lut_exp u_lut_exp (
      .i_idx (~in_atten[EXP_IDX_W-1:0]),
      .o_val (w_lut)
   );

   // Stage 1: mantissa lookup and shift amount.
   logic              r_s1_valid;
   logic              r_s1_sign;
   logic              r_s1_last;
   logic [MANT_W-1:0] r_s1_mant;
   logic [4:0]        r_s1_shift;

   // NOTE: sequential state always uses non-blocking (<=) so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) r_s1_valid <= 1'b0;
      else       r_s1_valid <= in_valid;
   end

   always_ff @(posedge clk) begin
      r_s1_mant  <= {1'b1, w_lut, 1'b0};
      r_s1_shift <= in_atten[ATTEN_W-1:EXP_IDX_W];
      r_s1_sign  <= in_sign;
      r_s1_last  <= in_last;
   end

   // Stage 2: the mantissa top bit is bit 11, so any shift >= 12 naturally yields zero.
   logic [SAMPLE_W-2:0] w_mag;
   logic [SAMPLE_W-1:0] w_sample;

   assign w_mag    = (SAMPLE_W-1)'({1'b0, r_s1_mant}) >> r_s1_shift;
   assign w_sample = r_s1_sign ? ~{1'b0, w_mag} : {1'b0, w_mag};

   logic                r_out_valid;
   logic                r_out_last;
   logic [SAMPLE_W-1:0] r_out_sample;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_sample <= '0;
      end else begin
         r_out_valid <= r_s1_valid;
         r_out_last  <= r_s1_last;
         if (r_s1_valid) r_out_sample <= w_sample;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_sample = r_out_sample;

   // Accumulator: the sum for this slot is formed combinationally from the registered sample.
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_acc_sample;
   logic             r_acc_valid;
   logic [ACC_W-1:0] w_addend;
   logic [ACC_W-1:0] w_sum;

   assign w_addend = {{(ACC_W-SAMPLE_W){r_out_sample[SAMPLE_W-1]}}, r_out_sample};

`ifdef EXP_ACC_SAT_EN
   logic [ACC_W:0] w_wide;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_wide = {r_acc[ACC_W-1], r_acc} + {w_addend[ACC_W-1], w_addend};
      w_sum  = w_wide[ACC_W-1:0];
      if (w_wide[ACC_W] != w_wide[ACC_W-1])
         w_sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign w_sum = r_acc + w_addend;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc        <= '0;
         r_acc_sample <= '0;
         r_acc_valid  <= 1'b0;
      end else begin
         r_acc_valid <= 1'b0;
         if (r_out_valid) begin
            if (r_out_last) begin
               r_acc_sample <= w_sum;
               r_acc        <= '0;
               r_acc_valid  <= 1'b1;
            end else begin
               r_acc <= w_sum;
            end
         end
      end
   end

   assign acc_valid  = r_acc_valid;
   assign acc_sample = r_acc_sample;

endmodule

// File: tb/tb_opl_exp_conv.sv
// Directed self-checking bench for opl_exp_conv: latency, octave/sign mapping, frame sums, reset.
module tb_opl_exp_conv;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [12:0] in_atten;
   logic        in_sign;
   logic        in_last;
   logic        out_valid;
   logic [13:0] out_sample;
   logic        acc_valid;
   logic [15:0] acc_sample;

   int n_checks = 0;
   int n_errors = 0;

   opl_exp_conv #(.ACC_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_atten   (in_atten),
      .in_sign    (in_sign),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_sample (out_sample),
      .acc_valid  (acc_valid),
      .acc_sample (acc_sample)
   );

   always #5 clk = ~clk;

   task automatic set_in(input logic v, input logic [12:0] a, input logic s, input logic l);
      in_valid = v;
      in_atten = a;
      in_sign  = s;
      in_last  = l;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(1'b0, 13'h0, 1'b0, 1'b0);
      repeat (3) tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
      end
      n_checks++;
      if (out_sample !== 14'h0) begin
         n_errors++; $display("FAIL reset_out_sample: got %h want 0", out_sample);
      end
      n_checks++;
      if (acc_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_acc_valid: got %0b want 0", acc_valid);
      end
      n_checks++;
      if (acc_sample !== 16'h0) begin
         n_errors++; $display("FAIL reset_acc_sample: got %h want 0", acc_sample);
      end
      reset = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (out_valid !== 1'b0 || acc_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: out_valid %0b acc_valid %0b want 0 0", out_valid, acc_valid);
      end
   endtask

   task automatic test_full_scale();
      tick();
      set_in(1'b1, 13'h0, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 13'h0, 1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++; $display("FAIL fs_early_valid: got %0b want 0 at N+1", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sample !== 14'd4084) begin
         n_errors++;
         $display("FAIL fs_sample: valid %0b sample %0d want 1 4084", out_valid, out_sample);
      end
      n_checks++;
      if (acc_valid !== 1'b0) begin
         n_errors++; $display("FAIL fs_acc_early: got %0b want 0 at N+2", acc_valid);
      end
      tick();
      n_checks++;
      if (acc_valid !== 1'b1 || acc_sample !== 16'd4084) begin
         n_errors++;
         $display("FAIL fs_acc: valid %0b acc %0d want 1 4084", acc_valid, acc_sample);
      end
      tick();
      n_checks++;
      if (acc_valid !== 1'b0 || acc_sample !== 16'd4084) begin
         n_errors++;
         $display("FAIL fs_acc_hold: valid %0b acc %0d want 0 4084", acc_valid, acc_sample);
      end
   endtask

   task automatic test_octave_sign();
      logic [12:0] atten_tab [11];
      logic        sign_tab  [11];
      logic [13:0] exp_tab   [11];
      atten_tab = '{13'h100, 13'h0FF, 13'h1FFF, 13'h0C00, 13'h3FF, 13'h580,
                    13'h07F, 13'hB00, 13'h000, 13'h100, 13'h1FFF};
      sign_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_tab   = '{14'd2042, 14'd2048, 14'd0, 14'd0, 14'd256, 14'd90,
                    14'd2896, 14'd1, 14'h300B, 14'h3805, 14'h3FFF};
      for (int i = 0; i < 11; i++) begin
         tick();
         set_in(1'b1, atten_tab[i], sign_tab[i], 1'b1);
         tick();
         set_in(1'b0, 13'h0, 1'b0, 1'b0);
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_sample !== exp_tab[i]) begin
            n_errors++;
            $display("FAIL octave_sign[%0d] atten %h sign %0b: valid %0b sample %h want 1 %h",
                     i, atten_tab[i], sign_tab[i], out_valid, out_sample, exp_tab[i]);
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      logic [12:0] atten_tab [4];
      logic        sign_tab  [4];
      logic        last_tab  [4];
      logic [13:0] exp_tab   [4];
      int          n_out;
      int          n_acc;
      logic [15:0] last_acc;
      atten_tab = '{13'h000, 13'h000, 13'h000, 13'h100};
      sign_tab  = '{1'b0, 1'b0, 1'b1, 1'b0};
      last_tab  = '{1'b0, 1'b0, 1'b0, 1'b1};
      exp_tab   = '{14'd4084, 14'd4084, 14'h300B, 14'd2042};
      n_out = 0; n_acc = 0; last_acc = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c < 4) set_in(1'b1, atten_tab[c], sign_tab[c], last_tab[c]);
         else       set_in(1'b0, 13'h0, 1'b0, 1'b0);
         if (out_valid === 1'b1) begin
            if (n_out < 4) begin
               n_checks++;
               if (out_sample !== exp_tab[n_out]) begin
                  n_errors++;
                  $display("FAIL b2b_sample[%0d]: got %h want %h", n_out, out_sample, exp_tab[n_out]);
               end
            end
            n_out++;
         end
         if (acc_valid === 1'b1) begin
            n_acc++;
            last_acc = acc_sample;
         end
      end
      n_checks++;
      if (n_out != 4) begin
         n_errors++; $display("FAIL b2b_out_count: got %0d want 4", n_out);
      end
      n_checks++;
      if (n_acc != 1) begin
         n_errors++; $display("FAIL b2b_acc_pulses: got %0d want 1", n_acc);
      end
      n_checks++;
      if (last_acc !== 16'd6125) begin
         n_errors++; $display("FAIL b2b_acc_sum: got %0d want 6125", $signed(last_acc));
      end
      // Fresh frame: a lone last slot must carry only its own value.
      n_acc = 0; last_acc = '0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c == 0) set_in(1'b1, 13'h100, 1'b0, 1'b1);
         else        set_in(1'b0, 13'h0, 1'b0, 1'b0);
         if (acc_valid === 1'b1) begin
            n_acc++;
            last_acc = acc_sample;
         end
      end
      n_checks++;
      if (n_acc != 1 || last_acc !== 16'd2042) begin
         n_errors++;
         $display("FAIL next_frame: pulses %0d acc %0d want 1 2042", n_acc, $signed(last_acc));
      end
   endtask

   task automatic test_overflow();
      int          n_acc;
      logic [15:0] last_acc;
      logic [15:0] exp_acc;
`ifdef EXP_ACC_SAT_EN
      exp_acc = 16'h7FFF;
`else
      exp_acc = 16'h8F94;
`endif
      n_acc = 0; last_acc = '0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (c < 9) set_in(1'b1, 13'h0, 1'b0, c == 8);
         else       set_in(1'b0, 13'h0, 1'b0, 1'b0);
         if (acc_valid === 1'b1) begin
            n_acc++;
            last_acc = acc_sample;
         end
      end
      n_checks++;
      if (n_acc != 1 || last_acc !== exp_acc) begin
         n_errors++;
         $display("FAIL overflow: pulses %0d acc %0d want 1 %0d",
                  n_acc, $signed(last_acc), $signed(exp_acc));
      end
   endtask

   task automatic test_reset_mid_frame();
      int          n_out;
      int          n_acc;
      logic [15:0] last_acc;
      for (int c = 0; c < 3; c++) begin
         tick();
         set_in(1'b1, 13'h000, 1'b0, 1'b0);
      end
      tick();
      set_in(1'b0, 13'h0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || acc_valid !== 1'b0 || acc_sample !== 16'h0) begin
         n_errors++;
         $display("FAIL mid_reset_state: out_valid %0b acc_valid %0b acc %h want 0 0 0",
                  out_valid, acc_valid, acc_sample);
      end
      n_out = 0; n_acc = 0; last_acc = '0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 2) set_in(1'b1, 13'h100, 1'b0, 1'b1);
         else        set_in(1'b0, 13'h0, 1'b0, 1'b0);
         if (out_valid === 1'b1) n_out++;
         if (acc_valid === 1'b1) begin
            n_acc++;
            last_acc = acc_sample;
         end
      end
      n_checks++;
      if (n_out != 1) begin
         n_errors++; $display("FAIL mid_reset_flush: out_valid count %0d want 1", n_out);
      end
      n_checks++;
      if (n_acc != 1 || last_acc !== 16'd2042) begin
         n_errors++;
         $display("FAIL mid_reset_acc: pulses %0d acc %0d want 1 2042", n_acc, $signed(last_acc));
      end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_octave_sign();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
